// File: rtl/pmc_ramp_ctrl.sv
// Proportional ramp controller for speed/direction with sensor overrides.
// One instance per TMR lane, between the command receiver and the motor drive.
`timescale 1ns/1ps
module pmc_ramp_ctrl #(
    parameter int unsigned W         = 4,
    parameter int unsigned DIV       = 4,
    parameter int unsigned KP_SHIFT  = 2,
    parameter int unsigned STEP_MAX  = 3,
    parameter int unsigned DEF_SPEED = 5,
    parameter int unsigned DEF_DIR   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] speed_cmd,
    input  logic [W-1:0] dir_cmd,
    input  logic [1:0]   mode,
    input  logic         f1,
    input  logic         f2,
    input  logic         b1,
    input  logic         b2,
    input  logic         estop,
    output logic [W-1:0] speed_o,
    output logic [W-1:0] dir_o,
    output logic         settled,
    output logic         tick_o
);

    localparam logic [W-1:0] MAXV = '1;
    localparam int unsigned  CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [W-1:0] DSPD = W'(DEF_SPEED);
    localparam logic [W-1:0] DDIR = W'(DEF_DIR);
    localparam logic [W-1:0] SMAX =
        (STEP_MAX > (2**W - 1)) ? '1 : W'(STEP_MAX);

    logic [3:0]    s_meta_q;
    logic [3:0]    s_sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick;
    logic [W-1:0]  spd_q;
    logic [W-1:0]  spd_d;
    logic [W-1:0]  dir_q;
    logic [W-1:0]  dir_d;
    logic          settled_q;
    logic          settled_d;
    logic [W-1:0]  nom_spd;
    logic [W-1:0]  nom_dir;
    logic [W-1:0]  tgt_spd;
    logic [W-1:0]  tgt_dir;
    logic          spd_fast;

    // One proportional step toward tgt; never overshoots, never wraps.
    function automatic logic [W-1:0] ramp_next(
        input logic [W-1:0] cur,
        input logic [W-1:0] tgt,
        input logic         fast
    );
        logic signed [W:0] err;
        logic [W-1:0]      mag;
        logic [W-1:0]      raw;
        logic [W-1:0]      step;
        err = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag = err[W] ? W'(-err) : err[W-1:0];
        raw = mag >> KP_SHIFT;
        if (fast) begin
            step = SMAX;
        end else if (raw == '0) begin
            step = W'(1);
        end else if (raw > SMAX) begin
            step = SMAX;
        end else begin
            step = raw;
        end
        if (mag <= step) begin
            ramp_next = tgt;
        end else if (err[W]) begin
            ramp_next = cur - step;
        end else begin
            ramp_next = cur + step;
        end
    endfunction

    // Two-flop synchroniser for the active-low proximity sensors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta_q <= '1;
            s_sync_q <= '1;
        end else begin
            s_meta_q <= {f1, f2, b1, b2};
            s_sync_q <= s_meta_q;
        end
    end

    // Update tick divider; tick is quiet while reset is held.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && !rst && (cnt_q == CNT_LAST);

    // Tick counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Target selection: estop, then mode-dependent sensor tables.
    always_comb begin
        nom_spd  = speed_cmd;
        nom_dir  = dir_cmd;
        tgt_spd  = '0;
        tgt_dir  = '0;
        spd_fast = 1'b0;
        if (mode == 2'd0 || mode == 2'd3) begin
            nom_spd = DSPD;
            nom_dir = DDIR;
        end
        if (estop) begin
            tgt_spd  = '0;
            tgt_dir  = dir_q;
            spd_fast = 1'b1;
        end else begin
            unique case (mode)
                2'd2: begin
                    tgt_spd = speed_cmd;
                    tgt_dir = dir_cmd;
                end
                2'd3: begin
                    case (s_sync_q)
                        4'b0011: begin tgt_spd = '0;      tgt_dir = nom_dir; end
                        4'b1100: begin tgt_spd = nom_spd; tgt_dir = nom_dir; end
                        4'b0111: begin tgt_spd = nom_spd; tgt_dir = MAXV;    end
                        4'b1011: begin tgt_spd = '0;      tgt_dir = '0;      end
                        4'b0100: begin tgt_spd = nom_spd; tgt_dir = MAXV;    end
                        4'b1000: begin tgt_spd = nom_spd; tgt_dir = '0;      end
                        default: begin tgt_spd = '0;      tgt_dir = nom_dir; end
                    endcase
                end
                default: begin
                    case (s_sync_q)
                        4'b0011: begin tgt_spd = '0;      tgt_dir = nom_dir; end
                        4'b1100: begin tgt_spd = MAXV;    tgt_dir = nom_dir; end
                        4'b0111: begin tgt_spd = nom_spd; tgt_dir = MAXV;    end
                        4'b1011: begin tgt_spd = nom_spd; tgt_dir = '0;      end
                        4'b0100: begin tgt_spd = MAXV;    tgt_dir = MAXV;    end
                        4'b1000: begin tgt_spd = MAXV;    tgt_dir = '0;      end
                        default: begin tgt_spd = nom_spd; tgt_dir = nom_dir; end
                    endcase
                end
            endcase
        end
    end

    // Next output values, applied only on a tick.
    always_comb begin
        spd_d     = spd_q;
        dir_d     = dir_q;
        settled_d = settled_q;
        if (tick) begin
            spd_d     = ramp_next(spd_q, tgt_spd, spd_fast);
            dir_d     = ramp_next(dir_q, tgt_dir, 1'b0);
            settled_d = (spd_d == tgt_spd) && (dir_d == tgt_dir);
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spd_q     <= '0;
            dir_q     <= '0;
            settled_q <= 1'b0;
        end else begin
            spd_q     <= spd_d;
            dir_q     <= dir_d;
            settled_q <= settled_d;
        end
    end

    assign speed_o = spd_q;
    assign dir_o   = dir_q;
    assign settled = settled_q;
    assign tick_o  = tick;

endmodule

// File: tb/tb_pmc_ramp_ctrl.sv
// Directed bench for pmc_ramp_ctrl: vector table plus hand sequences.
// A second instance with DIV=1 checks the per-cycle tick.
`timescale 1ns/1ps
module tb_pmc_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] speed_cmd;
    logic [3:0] dir_cmd;
    logic [1:0] mode;
    logic       f1, f2, b1, b2;
    logic       estop;
    logic [3:0] speed_o, dir_o;
    logic       settled, tick_o;
    logic [3:0] speed1, dir1;
    logic       settled1, tick1;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pmc_ramp_ctrl dut (
        .clk(clk), .rst(rst), .en(en),
        .speed_cmd(speed_cmd), .dir_cmd(dir_cmd), .mode(mode),
        .f1(f1), .f2(f2), .b1(b1), .b2(b2), .estop(estop),
        .speed_o(speed_o), .dir_o(dir_o),
        .settled(settled), .tick_o(tick_o)
    );

    pmc_ramp_ctrl #(.DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .speed_cmd(speed_cmd), .dir_cmd(dir_cmd), .mode(mode),
        .f1(f1), .f2(f2), .b1(b1), .b2(b2), .estop(estop),
        .speed_o(speed1), .dir_o(dir1),
        .settled(settled1), .tick_o(tick1)
    );

    typedef struct {
        logic [1:0] mode;
        logic [3:0] scmd;
        logic [3:0] dcmd;
        logic [3:0] sens;
        logic       estop;
        logic [3:0] es;
        logic [3:0] ed;
        logic       est;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [1:0] m, input logic [3:0] sc, input logic [3:0] dc,
        input logic [3:0] s, input logic e,
        input logic [3:0] es, input logic [3:0] ed, input logic st
    );
        vec_t v;
        v.mode = m; v.scmd = sc; v.dcmd = dc; v.sens = s; v.estop = e;
        v.es = es; v.ed = ed; v.est = st;
        return v;
    endfunction

    task automatic chk4(input string name, input logic [3:0] act,
                        input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for the tick cycle, then land just after its update edge.
    task automatic next_update(input string name);
        bit found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tick_o === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errs++;
            $display("FAIL %s: tick seen 0 required 1", name);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int nt;
        bit chg;

        rst = 1; en = 1; mode = 0; speed_cmd = 0; dir_cmd = 0;
        {f1, f2, b1, b2} = 4'b1111; estop = 0;

        // mode0 S=1111 ramp from reset to (5,8)
        tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 2, 3, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 3, 4, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 4, 5, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 5, 6, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 5, 7, 0));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 5, 8, 1));
        // mode3 S=1011 -> (0,0)
        tbl.push_back(mk(3, 0, 0, 4'b1011, 0, 4, 6, 0));
        tbl.push_back(mk(3, 0, 0, 4'b1011, 0, 3, 5, 0));
        tbl.push_back(mk(3, 0, 0, 4'b1011, 0, 2, 4, 0));
        tbl.push_back(mk(3, 0, 0, 4'b1011, 0, 1, 3, 0));
        tbl.push_back(mk(3, 0, 0, 4'b1011, 0, 0, 2, 0));
        tbl.push_back(mk(3, 0, 0, 4'b1011, 0, 0, 1, 0));
        tbl.push_back(mk(3, 0, 0, 4'b1011, 0, 0, 0, 1));
        // mode2 15/0, sensors ignored
        tbl.push_back(mk(2, 15, 0, 4'b0011, 0, 3, 0, 0));
        tbl.push_back(mk(2, 15, 0, 4'b0011, 0, 6, 0, 0));
        tbl.push_back(mk(2, 15, 0, 4'b0011, 0, 8, 0, 0));
        tbl.push_back(mk(2, 15, 0, 4'b0011, 0, 9, 0, 0));
        tbl.push_back(mk(2, 15, 0, 4'b0011, 0, 10, 0, 0));
        tbl.push_back(mk(2, 15, 0, 4'b0011, 0, 11, 0, 0));
        tbl.push_back(mk(2, 15, 0, 4'b0011, 0, 12, 0, 0));
        tbl.push_back(mk(2, 15, 0, 4'b0011, 0, 13, 0, 0));
        tbl.push_back(mk(2, 15, 0, 4'b0011, 0, 14, 0, 0));
        tbl.push_back(mk(2, 15, 0, 4'b0011, 0, 15, 0, 1));
        // mode2 15/6
        tbl.push_back(mk(2, 15, 6, 4'b1111, 0, 15, 1, 0));
        tbl.push_back(mk(2, 15, 6, 4'b1111, 0, 15, 2, 0));
        tbl.push_back(mk(2, 15, 6, 4'b1111, 0, 15, 3, 0));
        tbl.push_back(mk(2, 15, 6, 4'b1111, 0, 15, 4, 0));
        tbl.push_back(mk(2, 15, 6, 4'b1111, 0, 15, 5, 0));
        tbl.push_back(mk(2, 15, 6, 4'b1111, 0, 15, 6, 1));
        // estop: speed down by 3, dir held, mode ignored
        tbl.push_back(mk(2, 15, 6, 4'b1111, 1, 12, 6, 0));
        tbl.push_back(mk(2, 15, 6, 4'b1111, 1, 9, 6, 0));
        tbl.push_back(mk(0, 15, 6, 4'b0100, 1, 6, 6, 0));
        tbl.push_back(mk(2, 15, 6, 4'b1111, 1, 3, 6, 0));
        tbl.push_back(mk(2, 15, 6, 4'b1111, 1, 0, 6, 1));
        // estop released: ramp back up
        tbl.push_back(mk(2, 15, 6, 4'b1111, 0, 3, 6, 0));
        tbl.push_back(mk(2, 15, 6, 4'b1111, 0, 6, 6, 0));
        tbl.push_back(mk(2, 15, 6, 4'b1111, 0, 8, 6, 0));
        // mode1 tables and other mode patterns
        tbl.push_back(mk(1, 4, 10, 4'b0111, 0, 7, 8, 0));
        tbl.push_back(mk(1, 4, 10, 4'b0111, 0, 6, 9, 0));
        tbl.push_back(mk(1, 4, 10, 4'b1000, 0, 8, 7, 0));
        tbl.push_back(mk(0, 4, 10, 4'b0011, 0, 6, 8, 0));
        tbl.push_back(mk(3, 4, 10, 4'b1100, 0, 5, 8, 1));
        tbl.push_back(mk(3, 4, 10, 4'b0100, 0, 5, 9, 0));

        // reset state, tick suppressed even with en=1
        repeat (3) @(negedge clk);
        chk4("rst_speed", speed_o, 4'd0);
        chk4("rst_dir", dir_o, 4'd0);
        chk4("rst_settled", 4'(settled), 4'd0);
        chk4("rst_tick", 4'(tick_o), 4'd0);
        chk4("rst_tick_div1", 4'(tick1), 4'd0);
        rst = 0;

        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            speed_cmd = tbl[i].scmd;
            dir_cmd = tbl[i].dcmd;
            {f1, f2, b1, b2} = tbl[i].sens;
            estop = tbl[i].estop;
            next_update($sformatf("vec%0d_tick", i));
            chk4($sformatf("vec%0d_speed", i), speed_o, tbl[i].es);
            chk4($sformatf("vec%0d_dir", i), dir_o, tbl[i].ed);
            chk4($sformatf("vec%0d_settled", i), 4'(settled),
                 4'(tbl[i].est));
        end

        // tick period: 4 for DIV=4, every cycle for DIV=1
        mode = 2; speed_cmd = 15; dir_cmd = 9;
        k = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            k++;
            chk4("div1_tick", 4'(tick1), 4'd1);
            if (tick_o === 1'b1) break;
        end
        chk_i("tick_period", k, 4);
        @(posedge clk);
        #1;
        chk4("div_speed", speed_o, 4'd7);
        chk4("div_dir", dir_o, 4'd9);

        // en low for 10 clk: frozen
        en = 0;
        nt = 0;
        chg = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (tick_o !== 1'b0 || tick1 !== 1'b0) nt++;
            if (speed_o !== 4'd7 || dir_o !== 4'd9) chg = 1;
        end
        chk_i("freeze_ticks", nt, 0);
        chk_i("freeze_change", int'(chg), 0);
        en = 1;
        next_update("resume_tick");
        chk4("resume_speed", speed_o, 4'd9);
        chk4("resume_dir", dir_o, 4'd9);

        // async reset between ticks mid-ramp
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk4("arst_speed", speed_o, 4'd0);
        chk4("arst_dir", dir_o, 4'd0);
        chk4("arst_settled", 4'(settled), 4'd0);
        @(negedge clk);
        rst = 0;
        k = 0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
            k++;
            if (speed_o !== 4'd0) break;
        end
        chk_i("arst_first_update", k, 4);
        chk4("arst_speed1", speed_o, 4'd3);
        chk4("arst_dir1", dir_o, 4'd2);

        // settle in mode0, then a sub-cycle sensor glitch
        mode = 0;
        {f1, f2, b1, b2} = 4'b1111;
        for (int j = 0; j < 20; j++) begin
            next_update("settle_tick");
            if (settled === 1'b1) break;
        end
        chk4("settle_flag", 4'(settled), 4'd1);
        chk4("settle_speed", speed_o, 4'd5);
        chk4("settle_dir", dir_o, 4'd8);
        f1 = 0;
        #3;
        f1 = 1;
        next_update("glitch_tick1");
        next_update("glitch_tick2");
        chk4("glitch_speed", speed_o, 4'd5);
        chk4("glitch_dir", dir_o, 4'd8);
        chk4("glitch_settled", 4'(settled), 4'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
